// File: rtl/vctrl_pkg.sv
// Shared opcodes, ALU codes, control bundle and sequencer state for the vector control pipe.
package vctrl_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpVv    = 6'b010000;
    localparam logic [5:0] OpVs    = 6'b010001;
    localparam logic [5:0] OpVlw   = 6'b110010;
    localparam logic [5:0] OpVsw   = 6'b110011;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef enum logic [0:0] {StIdle, StSeq} seq_state_t;

    typedef struct packed {
        logic [2:0] alucontrol;
        logic       alusrc;
        logic       scalar;
        logic       regdst;
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       memdata;
        logic       memsrc;
        logic       vregwrite;
        logic       vector;
        logic       multibeat;
    } ctrl_bundle_t;

    // Lane mask for the final beat: only the elements left over after the full beats.
    function automatic logic [63:0] tail_mask(input int unsigned vlen, input int unsigned lanes);
        int unsigned beats;
        int unsigned rem;
        beats = (vlen + lanes - 1) / lanes;
        rem   = vlen - (beats - 1) * lanes;
        if (rem >= 64) return '1;
        return (64'd1 << rem) - 64'd1;
    endfunction

endpackage

// File: rtl/vctrl_decoder.sv
// Combinational decode of opD/functD into the pipeline control bundle plus D-stage branch/jump.
module vctrl_decoder
    import vctrl_pkg::*;
(
    input  logic [5:0]   opD,
    input  logic [5:0]   functD,
    output ctrl_bundle_t ctrl,
    output logic         jump,
    output logic [1:0]   branch
);

    logic unusedFunct;
    assign unusedFunct = ^functD[5:3];

    always_comb begin
        ctrl   = '0;
        jump   = 1'b0;
        branch = 2'b00;
        case (opD)
            OpRtype: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = 1'b1;
                ctrl.alucontrol = functD[2:0];
            end
            OpAddi: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.alucontrol = AluAdd;
            end
            OpLw: begin
                ctrl.regwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.memtoreg   = 1'b1;
                ctrl.alucontrol = AluAdd;
            end
            OpSw: begin
                ctrl.memwrite   = 1'b1;
                ctrl.alusrc     = 1'b1;
                ctrl.alucontrol = AluAdd;
            end
            OpBeq: branch = 2'b01;
            OpBne: branch = 2'b10;
            OpJ:   jump   = 1'b1;
            OpVv, OpVs: begin
                ctrl.vregwrite  = 1'b1;
                ctrl.alucontrol = functD[2:0];
                ctrl.scalar     = (opD == OpVs);
                ctrl.vector     = 1'b1;
                ctrl.multibeat  = 1'b1;
            end
            OpVlw: begin
                ctrl.vregwrite = 1'b1;
                ctrl.memtoreg  = 1'b1;
                ctrl.memsrc    = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.vector    = 1'b1;
                ctrl.multibeat = 1'b1;
            end
            OpVsw: begin
                ctrl.memwrite  = 1'b1;
                ctrl.memdata   = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.vector    = 1'b1;
                ctrl.multibeat = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vec_control_pipe.sv
// Scalar/vector pipeline control: D decode, branch resolve, multi-beat vector sequencing, E/M/W regs.
// Define VCTRL_TAIL_MASK_EN to mask unused lanes on the final beat when VLEN is not a LANES multiple.
module vec_control_pipe
    import vctrl_pkg::*;
#(
    parameter int unsigned VLEN  = 8,
    parameter int unsigned LANES = 4,
    localparam int unsigned BEATS = (VLEN + LANES - 1) / LANES,
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opD,
    input  logic [5:0]       functD,
    input  logic [31:0]      srca2D,
    input  logic [31:0]      srcb2D,
    input  logic             flushE,
    output logic             jumpD,
    output logic             pcsrcD,
    output logic [1:0]       branchD,
    output logic             stallD,
    output logic [2:0]       alucontrolE,
    output logic             alusrcE,
    output logic             scalarE,
    output logic             regdstE,
    output logic             regwriteE,
    output logic             memtoregE,
    output logic [BW-1:0]    beatE,
    output logic [LANES-1:0] laneenE,
    output logic             memwriteM,
    output logic             memdataM,
    output logic             memsrcM,
    output logic             regwriteM,
    output logic             memtoregM,
    output logic             regwriteW,
    output logic             VregwriteW,
    output logic             memtoregW
);

    localparam bit            MultiBeat = (BEATS > 1);
    localparam logic [BW-1:0] LastBeat  = BW'(BEATS - 1);

`ifdef VCTRL_TAIL_MASK_EN
    localparam logic [LANES-1:0] TailMask = LANES'(tail_mask(VLEN, LANES));
`else
    localparam logic [LANES-1:0] TailMask = {LANES{1'b1}};
    if (VLEN % LANES != 0) begin : genLenCheck
        $error("vec_control_pipe: VLEN must be a multiple of LANES without tail masking");
    end
`endif

    ctrl_bundle_t dec;
    ctrl_bundle_t eQ;
    ctrl_bundle_t mQ;
    ctrl_bundle_t wQ;
    seq_state_t   stateQ;
    logic [BW-1:0] cntQ;
    logic [BW-1:0] issueBeat;

    vctrl_decoder uDecoder (
        .opD    (opD),
        .functD (functD),
        .ctrl   (dec),
        .jump   (jumpD),
        .branch (branchD)
    );

    assign pcsrcD = (branchD == 2'b01 && srca2D == srcb2D) ||
                    (branchD == 2'b10 && srca2D != srcb2D);

    assign issueBeat = (stateQ == StSeq) ? cntQ : '0;

    // A flushed beat is reissued, so the final beat keeps D stalled while it is being flushed.
    assign stallD = !reset &&
                    ((stateQ == StIdle && dec.multibeat && MultiBeat) ||
                     (stateQ == StSeq && (cntQ != LastBeat || flushE)));

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
            cntQ   <= '0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (dec.multibeat && MultiBeat) begin
                        stateQ <= StSeq;
                        cntQ   <= BW'(1);
                    end
                end
                StSeq: begin
                    if (!flushE) begin
                        if (cntQ == LastBeat) begin
                            stateQ <= StIdle;
                            cntQ   <= '0;
                        end else begin
                            cntQ <= cntQ + BW'(1);
                        end
                    end
                end
                default: begin
                    stateQ <= StIdle;
                    cntQ   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flushE) begin
            eQ      <= '0;
            beatE   <= '0;
            laneenE <= '0;
        end else begin
            eQ <= dec;
            if (dec.multibeat) begin
                beatE   <= issueBeat;
                laneenE <= (issueBeat == LastBeat) ? TailMask : {LANES{1'b1}};
            end else begin
                beatE   <= '0;
                laneenE <= {LANES{1'b1}};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mQ <= '0;
            wQ <= '0;
        end else begin
            mQ <= eQ;
            wQ <= mQ;
        end
    end

    assign alucontrolE = eQ.alucontrol;
    assign alusrcE     = eQ.alusrc;
    assign scalarE     = eQ.scalar;
    assign regdstE     = eQ.regdst;
    assign regwriteE   = eQ.regwrite;
    assign memtoregE   = eQ.memtoreg;

    assign memwriteM = mQ.memwrite;
    assign memdataM  = mQ.memdata;
    assign memsrcM   = mQ.memsrc;
    assign regwriteM = mQ.regwrite;
    assign memtoregM = mQ.memtoreg;

    assign regwriteW  = wQ.regwrite;
    assign VregwriteW = wQ.vregwrite;
    assign memtoregW  = wQ.memtoreg;

    logic unusedW;
    assign unusedW = ^{wQ.alucontrol, wQ.alusrc, wQ.scalar, wQ.regdst, wQ.memwrite,
                       wQ.memdata, wQ.memsrc, wQ.vector, wQ.multibeat};

endmodule

// File: tb/tb_vec_control_pipe.sv
// Directed bench for vec_control_pipe: VLEN/LANES 8/4 and 16/4 always, 6/4 with VCTRL_TAIL_MASK_EN.
module tb_vec_control_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opD;
    logic [5:0]  functD;
    logic [31:0] srca2D;
    logic [31:0] srcb2D;
    logic        flushE;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // VLEN=8, LANES=4
    logic       aJump, aPcsrc, aStall, aAlusrc, aScalar, aRegdst, aRegwriteE, aMemtoregE;
    logic [1:0] aBranch;
    logic [2:0] aAlu;
    logic [0:0] aBeat;
    logic [3:0] aLaneen;
    logic       aMemwriteM, aMemdataM, aMemsrcM, aRegwriteM, aMemtoregM;
    logic       aRegwriteW, aVregwriteW, aMemtoregW;

    // VLEN=16, LANES=4
    logic       bJump, bPcsrc, bStall, bAlusrc, bScalar, bRegdst, bRegwriteE, bMemtoregE;
    logic [1:0] bBranch;
    logic [2:0] bAlu;
    logic [1:0] bBeat;
    logic [3:0] bLaneen;
    logic       bMemwriteM, bMemdataM, bMemsrcM, bRegwriteM, bMemtoregM;
    logic       bRegwriteW, bVregwriteW, bMemtoregW;

    vec_control_pipe #(.VLEN(8), .LANES(4)) dutA (
        .clk(clk), .reset(reset), .opD(opD), .functD(functD), .srca2D(srca2D), .srcb2D(srcb2D),
        .flushE(flushE), .jumpD(aJump), .pcsrcD(aPcsrc), .branchD(aBranch), .stallD(aStall),
        .alucontrolE(aAlu), .alusrcE(aAlusrc), .scalarE(aScalar), .regdstE(aRegdst),
        .regwriteE(aRegwriteE), .memtoregE(aMemtoregE), .beatE(aBeat), .laneenE(aLaneen),
        .memwriteM(aMemwriteM), .memdataM(aMemdataM), .memsrcM(aMemsrcM),
        .regwriteM(aRegwriteM), .memtoregM(aMemtoregM), .regwriteW(aRegwriteW),
        .VregwriteW(aVregwriteW), .memtoregW(aMemtoregW)
    );

    vec_control_pipe #(.VLEN(16), .LANES(4)) dutB (
        .clk(clk), .reset(reset), .opD(opD), .functD(functD), .srca2D(srca2D), .srcb2D(srcb2D),
        .flushE(flushE), .jumpD(bJump), .pcsrcD(bPcsrc), .branchD(bBranch), .stallD(bStall),
        .alucontrolE(bAlu), .alusrcE(bAlusrc), .scalarE(bScalar), .regdstE(bRegdst),
        .regwriteE(bRegwriteE), .memtoregE(bMemtoregE), .beatE(bBeat), .laneenE(bLaneen),
        .memwriteM(bMemwriteM), .memdataM(bMemdataM), .memsrcM(bMemsrcM),
        .regwriteM(bRegwriteM), .memtoregM(bMemtoregM), .regwriteW(bRegwriteW),
        .VregwriteW(bVregwriteW), .memtoregW(bMemtoregW)
    );

`ifdef VCTRL_TAIL_MASK_EN
    // VLEN=6, LANES=4: last beat carries two elements
    logic       cJump, cPcsrc, cStall, cAlusrc, cScalar, cRegdst, cRegwriteE, cMemtoregE;
    logic [1:0] cBranch;
    logic [2:0] cAlu;
    logic [0:0] cBeat;
    logic [3:0] cLaneen;
    logic       cMemwriteM, cMemdataM, cMemsrcM, cRegwriteM, cMemtoregM;
    logic       cRegwriteW, cVregwriteW, cMemtoregW;

    vec_control_pipe #(.VLEN(6), .LANES(4)) dutC (
        .clk(clk), .reset(reset), .opD(opD), .functD(functD), .srca2D(srca2D), .srcb2D(srcb2D),
        .flushE(flushE), .jumpD(cJump), .pcsrcD(cPcsrc), .branchD(cBranch), .stallD(cStall),
        .alucontrolE(cAlu), .alusrcE(cAlusrc), .scalarE(cScalar), .regdstE(cRegdst),
        .regwriteE(cRegwriteE), .memtoregE(cMemtoregE), .beatE(cBeat), .laneenE(cLaneen),
        .memwriteM(cMemwriteM), .memdataM(cMemdataM), .memsrcM(cMemsrcM),
        .regwriteM(cRegwriteM), .memtoregM(cMemtoregM), .regwriteW(cRegwriteW),
        .VregwriteW(cVregwriteW), .memtoregW(cMemtoregW)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        opD    = 6'b000000;
        functD = 6'b000000;
        srca2D = 32'h0;
        srcb2D = 32'h0;
        flushE = 1'b0;

        // Reset for two cycles
        tick();
        tick();
        check("rst_regwriteE", aRegwriteE, 0);
        check("rst_regwriteW", aRegwriteW, 0);
        check("rst_laneenE", aLaneen, 0);
        check("rst_stallD", aStall, 0);

        // Scalar R-type through E, M, W
        reset  = 1'b0;
        functD = 6'b000010;
        #1;
        check("r_pre_regwriteE", aRegwriteE, 0);
        tick();
        check("r_regwriteE", aRegwriteE, 1);
        check("r_regdstE", aRegdst, 1);
        check("r_alucontrolE", aAlu, 3'b010);
        check("r_beatE", aBeat, 0);
        check("r_laneenE", aLaneen, 4'hF);
        check("r_regwriteW_early", aRegwriteW, 0);
        opD = 6'b111111;
        tick();
        check("r_regwriteM", aRegwriteM, 1);
        check("r_nop_regwriteE", aRegwriteE, 0);
        check("r_regwriteW_mid", aRegwriteW, 0);
        tick();
        check("r_regwriteW", aRegwriteW, 1);

        // Branch resolve in D
        opD    = 6'b000100;
        srca2D = 32'h5;
        srcb2D = 32'h5;
        #1;
        check("beq_branchD", aBranch, 2'b01);
        check("beq_taken", aPcsrc, 1);
        srcb2D = 32'h6;
        #1;
        check("beq_not_taken", aPcsrc, 0);
        opD = 6'b000101;
        #1;
        check("bne_branchD", aBranch, 2'b10);
        check("bne_taken", aPcsrc, 1);
        opD = 6'b000010;
        #1;
        check("j_jumpD", aJump, 1);
        check("j_pcsrcD", aPcsrc, 0);

        // lw then sw
        opD = 6'b100011;
        tick();
        check("lw_memtoregE", aMemtoregE, 1);
        check("lw_alusrcE", aAlusrc, 1);
        check("lw_regwriteE", aRegwriteE, 1);
        opD = 6'b101011;
        tick();
        opD = 6'b111111;
        tick();
        check("sw_memwriteM", aMemwriteM, 1);
        check("sw_memdataM", aMemdataM, 0);
        check("sw_regwriteM", aRegwriteM, 0);

        // Two-beat vector-vector op on 8/4
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        opD    = 6'b010000;
        functD = 6'b000110;
        #1;
        check("vv_stall_beat0", aStall, 1);
        tick();
        check("vv_beatE0", aBeat, 0);
        check("vv_laneenE0", aLaneen, 4'hF);
        check("vv_alucontrolE", aAlu, 3'b110);
        check("vv_regwriteE", aRegwriteE, 0);
        check("vv_stall_beat1", aStall, 0);
        tick();
        check("vv_beatE1", aBeat, 1);
        check("vv_laneenE1", aLaneen, 4'hF);
        opD = 6'b111111;
        #1;
        check("vv_stall_after", aStall, 0);
        check("vv_vregwriteW_early", aVregwriteW, 0);
        tick();
        check("vv_vregwriteW_beat0", aVregwriteW, 1);
        tick();
        check("vv_vregwriteW_beat1", aVregwriteW, 1);
        tick();
        check("vv_vregwriteW_done", aVregwriteW, 0);

        // Four-beat vlw on 16/4 with a flush at beat 2
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        opD    = 6'b110010;
        functD = 6'b000000;
        #1;
        check("vlw_stall_c1", bStall, 1);
        tick();
        check("vlw_beatE0", bBeat, 0);
        check("vlw_memtoregE0", bMemtoregE, 1);
        check("vlw_alusrcE0", bAlusrc, 1);
        check("vlw_stall_c2", bStall, 1);
        tick();
        check("vlw_beatE1", bBeat, 1);
        check("vlw_memsrcM", bMemsrcM, 1);
        flushE = 1'b1;
        #1;
        check("vlw_stall_c3", bStall, 1);
        tick();
        check("flush_beatE", bBeat, 0);
        check("flush_memtoregE", bMemtoregE, 0);
        check("flush_alusrcE", bAlusrc, 0);
        check("flush_laneenE", bLaneen, 0);
        flushE = 1'b0;
        #1;
        check("vlw_stall_c4", bStall, 1);
        tick();
        check("vlw_beatE2_reissue", bBeat, 2);
        check("vlw_memtoregE2", bMemtoregE, 1);
        check("vlw_memtoregW_beat1", bMemtoregW, 1);
        check("vlw_stall_last", bStall, 0);
        tick();
        check("vlw_beatE3", bBeat, 3);
        check("vlw_laneenE3", bLaneen, 4'hF);
        check("vlw_memtoregW_bubble", bMemtoregW, 0);
        opD = 6'b111111;
        #1;
        check("vlw_stall_after", bStall, 0);

        // Reset in the middle of a four-beat vector-scalar op
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        opD    = 6'b010001;
        functD = 6'b000010;
        tick();
        check("vs_scalarE", bScalar, 1);
        check("vs_beatE0", bBeat, 0);
        check("vs_alucontrolE", bAlu, 3'b010);
        tick();
        check("vs_beatE1", bBeat, 1);
        reset = 1'b1;
        #1;
        check("midrst_stall_same", bStall, 0);
        tick();
        reset = 1'b0;
        opD   = 6'b111111;
        #1;
        check("midrst_stallD", bStall, 0);
        check("midrst_scalarE", bScalar, 0);
        check("midrst_beatE", bBeat, 0);
        check("midrst_laneenE", bLaneen, 0);
        check("midrst_vregwriteW", bVregwriteW, 0);
        check("midrst_regwriteM", bRegwriteM, 0);
        tick();
        check("midrst_idle_stall", bStall, 0);
        check("midrst_idle_laneen", bLaneen, 4'hF);

`ifdef VCTRL_TAIL_MASK_EN
        // vsw on 6/4: tail beat covers lanes 0 and 1 only
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        opD    = 6'b110011;
        functD = 6'b000000;
        tick();
        check("vsw_beatE0", cBeat, 0);
        check("vsw_laneenE0", cLaneen, 4'hF);
        tick();
        check("vsw_beatE1", cBeat, 1);
        check("vsw_laneenE1_tail", cLaneen, 4'b0011);
        check("vsw_memwriteM0", cMemwriteM, 1);
        check("vsw_memdataM0", cMemdataM, 1);
        opD = 6'b111111;
        tick();
        check("vsw_memwriteM1", cMemwriteM, 1);
        check("vsw_memdataM1", cMemdataM, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
